key_led_sequencer: RTL

//  Turns one raw, bouncy, active-low push-button into a 4-mode LED controller:
//  OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF, advancing one mode per debounced press.
//  A long press forces OFF from any mode.

---
 rtl/key_led_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/key_led_sequencer.sv
// Single-button LED mode controller: synchronise and debounce an active-low key,
// step OFF -> ON -> BLINK_SLOW -> BLINK_FAST on each press, force OFF on a long hold.
module key_led_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 500_000,
    parameter int SLOW_HALF         = 25_000_000,
    parameter int FAST_HALF         = 6_250_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       kill,
    input  logic       key,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_pulse,
    output logic       long_pulse
);

    localparam int HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int DW       = $clog2(DEBOUNCE_CYCLES);
    localparam int PW       = $clog2(HALF_MAX);
    localparam int LW       = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_HALF - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_HALF - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        ON         = 2'd1,
        BLINK_SLOW = 2'd2,
        BLINK_FAST = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          sync_a;
    logic          sync_b;
    logic          key_db;
    logic [DW-1:0] db_cnt;
    logic          db_flip;
    logic          press_acc;
    logic          release_acc;
    logic [LW-1:0] hold_cnt;
    logic          long_fire;
    logic          mode_event;
    logic [PW-1:0] half_last;
    logic [PW-1:0] phase_cnt;

    // Two-flop synchroniser; idles at the released level (1).
    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
        end
    end

    // key_db follows the active-low pin: 1 = released, 0 = pressed.
    assign db_flip     = (sync_b != key_db) && (db_cnt == DEB_LAST);
    assign press_acc   = db_flip && key_db;
    assign release_acc = db_flip && !key_db;

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            key_db <= 1'b1;
            db_cnt <= '0;
        end else if (sync_b == key_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DEB_LAST) begin
            key_db <= sync_b;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Hold counter parks one past the trigger value so a held key fires only once.
    assign long_fire = !key_db && !release_acc && (hold_cnt == LONG_LAST);

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            hold_cnt <= '0;
        end else if (press_acc || release_acc) begin
            hold_cnt <= '0;
        end else if (!key_db && (hold_cnt != LONG_SAT)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) state_q <= OFF;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (long_fire) begin
            state_d = OFF;
        end else if (press_acc) begin
            case (state_q)
                OFF:        state_d = ON;
                ON:         state_d = BLINK_SLOW;
                BLINK_SLOW: state_d = BLINK_FAST;
                default:    state_d = OFF;
            endcase
        end
    end

    always_comb begin
        mode       = state_q;
        mode_event = press_acc || long_fire;
        half_last  = (state_q == BLINK_SLOW) ? SLOW_LAST : FAST_LAST;
    end

    // Any mode event restarts the blink phase with the LED lit (unless going OFF).
    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            led       <= 1'b0;
            phase_cnt <= '0;
        end else if (mode_event) begin
            led       <= (state_d != OFF);
            phase_cnt <= '0;
        end else begin
            case (state_q)
                OFF: led <= 1'b0;
                ON:  led <= 1'b1;
                default: begin
                    if (phase_cnt == half_last) begin
                        led       <= ~led;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            press_pulse <= press_acc;
            long_pulse  <= long_fire;
        end
    end

endmodule
